instr_stream_encoder: RTL

- Writer-side counterpart of the control decoder: accepts symbolic LEGv8 instruction requests (op kind plus fields) and encodes each into a 32-bit machine word.
- Encoded words are buffered in a small FIFO and streamed into the instruction-memory write port at sequential word addresses.
- Used by the program loader and self-test harness to build programs that the fetch/decode path later executes.

---
 rtl/instr_enc_pkg.sv | 55 +++++
 rtl/instr_stream_encoder_fifo.sv | 47 ++++
 rtl/instr_stream_encoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/instr_enc_pkg.sv
// Shared LEGv8 encoding constants, op kinds and stream-writer state for the
// instruction encoder and the control decoder.
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_ADDI  = 4'd1,
    OP_ADDS  = 4'd2,
    OP_SUB   = 4'd3,
    OP_SUBS  = 4'd4,
    OP_LDUR  = 4'd5,
    OP_STUR  = 4'd6,
    OP_LDURB = 4'd7,
    OP_STURB = 4'd8,
    OP_B     = 4'd9,
    OP_CBZ   = 4'd10,
    OP_B_LT  = 4'd11,
    OP_MOVZ  = 4'd12,
    OP_MOVK  = 4'd13
  } op_kind_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [10:0] OPC_ADD   = 11'b10001011000;
  localparam logic [10:0] OPC_ADDS  = 11'b10101011000;
  localparam logic [10:0] OPC_SUB   = 11'b11001011000;
  localparam logic [10:0] OPC_SUBS  = 11'b11101011000;
  localparam logic [9:0]  OPC_ADDI  = 10'b1001000100;
  localparam logic [10:0] OPC_LDUR  = 11'b11111000010;
  localparam logic [10:0] OPC_STUR  = 11'b11111000000;
  localparam logic [10:0] OPC_LDURB = 11'b00111000010;
  localparam logic [10:0] OPC_STURB = 11'b00111000000;
  localparam logic [5:0]  OPC_B     = 6'b000101;
  localparam logic [7:0]  OPC_CBZ   = 8'b10110100;
  localparam logic [7:0]  OPC_BCOND = 8'b01010100;
  localparam logic [8:0]  OPC_MOVZ  = 9'b110100101;
  localparam logic [8:0]  OPC_MOVK  = 9'b111100101;
  localparam logic [4:0]  COND_LT   = 5'b01011;

  // True when v, read as two's complement, fits in a w-bit signed field.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned w);
    logic [31:0] hi;
    hi = $signed(v) >>> (w - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic logic fits_unsigned(input logic [31:0] v, input int unsigned w);
    return (v >> w) == '0;
  endfunction

endpackage

// File: rtl/instr_stream_encoder_fifo.sv
// Synchronous FIFO with extra-bit pointers; head word is visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: storage is not reset; only the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes symbolic LEGv8 requests into machine words and streams them through
// a FIFO into the instruction-memory write port at sequential word addresses.
module instr_stream_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [31:0]       in_imm,
  input  logic [1:0]        in_hw,
  input  logic              flush,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_wr_ready,
  output logic              enc_err,
  output logic [7:0]        err_count,
  output logic              done
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_enc_err;
  logic [7:0]        r_err_count;
  logic [31:0]       w_word;
  logic [31:0]       w_head;
  logic              w_legal;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (op_kind_e'(in_op))
      OP_ADD:   w_word = {OPC_ADD,  in_rm, 6'd0, in_rn, in_rd};
      OP_ADDS:  w_word = {OPC_ADDS, in_rm, 6'd0, in_rn, in_rd};
      OP_SUB:   w_word = {OPC_SUB,  in_rm, 6'd0, in_rn, in_rd};
      OP_SUBS:  w_word = {OPC_SUBS, in_rm, 6'd0, in_rn, in_rd};
      OP_ADDI: begin
        w_legal = fits_unsigned(in_imm, 12);
        w_word  = {OPC_ADDI, in_imm[11:0], in_rn, in_rd};
      end
      OP_LDUR, OP_STUR, OP_LDURB, OP_STURB: begin
        w_legal = fits_signed(in_imm, 9);
        case (op_kind_e'(in_op))
          OP_LDUR:  w_word = {OPC_LDUR,  in_imm[8:0], 2'b00, in_rn, in_rd};
          OP_STUR:  w_word = {OPC_STUR,  in_imm[8:0], 2'b00, in_rn, in_rd};
          OP_LDURB: w_word = {OPC_LDURB, in_imm[8:0], 2'b00, in_rn, in_rd};
          default:  w_word = {OPC_STURB, in_imm[8:0], 2'b00, in_rn, in_rd};
        endcase
      end
      OP_B: begin
        w_legal = fits_signed(in_imm, 26);
        w_word  = {OPC_B, in_imm[25:0]};
      end
      OP_CBZ: begin
        w_legal = fits_signed(in_imm, 19);
        w_word  = {OPC_CBZ, in_imm[18:0], in_rd};
      end
      OP_B_LT: begin
        w_legal = fits_signed(in_imm, 19);
        w_word  = {OPC_BCOND, in_imm[18:0], COND_LT};
      end
      OP_MOVZ: begin
        w_legal = fits_unsigned(in_imm, 16);
        w_word  = {OPC_MOVZ, in_hw, in_imm[15:0], in_rd};
      end
      OP_MOVK: begin
        w_legal = fits_unsigned(in_imm, 16);
        w_word  = {OPC_MOVK, in_hw, in_imm[15:0], in_rd};
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal requests are handshaken but never reach the FIFO.
  assign in_ready = (r_state == ST_RUN) && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_empty && imem_wr_ready;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_word),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:   if (flush) w_state_next = (w_empty && !w_push) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (w_empty) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= BASE;
      r_enc_err   <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_enc_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (r_state == ST_DONE) r_addr <= BASE;
      else if (w_pop)         r_addr <= r_addr + ADDR_W'(4);
    end
  end

  assign imem_wr_en = !w_empty;
  assign imem_addr  = r_addr;
  assign imem_wdata = w_empty ? 32'd0 : w_head;
  assign enc_err    = r_enc_err;
  assign err_count  = r_err_count;
  assign done       = (r_state == ST_DONE);

endmodule
